// File: rtl/encoder8_3.sv
// 8-to-3 priority encoder with one-hot checking, a 2-entry result FIFO
// and a saturating count of non-one-hot words.
module encoder8_3 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [7:0]       in,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out,
    output logic             err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [2:0] enc_idx;
    logic [3:0] pop_cnt;
    logic       enc_err;

    // Ascending scan so the highest set bit is the last one to write enc_idx.
    always_comb begin
        enc_idx = '0;
        pop_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            if (in[i]) begin
                enc_idx = 3'(i);
                pop_cnt = pop_cnt + 4'd1;
            end
        end
        enc_err = (pop_cnt != 4'd1);
    end

    logic [3:0]       slot_q [2];
    logic [3:0]       slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             push, pop;
    logic [3:0]       head;

    // en_q keeps ready low until the first clock edge after reset release.
    assign ready     = en_q & rst & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = valid & ready;
    assign pop       = out_valid & out_ready;
    assign head      = slot_q[rd_ptr_q];
    assign out       = out_valid ? head[3:1] : 3'd0;
    assign err       = out_valid ? head[0] : 1'b0;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        en_d     = 1'b1;
        if (push) begin
            slot_d[wr_ptr_q] = {enc_idx, enc_err};
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Clear takes priority over a same-cycle increment; the count saturates.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (push && enc_err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            en_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            en_q      <= en_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_encoder8_3.sv
// Directed bench for encoder8_3: one task per scenario, hand-computed expectations.
module tb_encoder8_3;

    logic       clk;
    logic       rst;
    logic       valid, out_ready, clr_cnt;
    logic [7:0] in;
    logic       ready, out_valid, err;
    logic [2:0] out;
    logic [7:0] err_cnt;

    logic       valid2, out_ready2, clr_cnt2;
    logic [7:0] in2;
    logic       ready2, out_valid2, err2;
    logic [2:0] out2;
    logic [1:0] err_cnt2;

    int errors = 0;
    int checks = 0;

    encoder8_3 #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .in(in), .ready(ready),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .err(err),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    encoder8_3 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .valid(valid2), .in(in2), .ready(ready2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out(out2), .err(err2),
        .clr_cnt(clr_cnt2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 0; in = 0; out_ready = 0; clr_cnt = 0;
        valid2 = 0; in2 = 0; out_ready2 = 0; clr_cnt2 = 0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || out !== 3'd0 || err !== 1'b0 || err_cnt !== 8'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b out=%0d err=%b cnt=%0d rdy=%b, want 0 0 0 0 0",
                     out_valid, out, err, err_cnt, ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready_early: ready=%b want 0", ready);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: ready=%b ov=%b want 1 0", ready, out_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_sweep();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            valid = 1; in = 8'(1 << i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out !== 3'(i) || err !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_%0d: ov=%b out=%0d err=%b rdy=%b want 1 %0d 0 1",
                         i, out_valid, out, err, ready, i);
            end
            $display("sweep: in=%h out=%0d err=%b", in, out, err);
        end
        valid = 0; in = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out !== 3'd0 || err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sweep_drain: ov=%b out=%0d err=%b cnt=%0d want 0 0 0 0",
                     out_valid, out, err, err_cnt);
        end
    endtask

    task automatic test_bad_words();
        logic [7:0] words [3];
        logic [2:0] exp_out [3];
        words[0] = 8'h00; words[1] = 8'h24; words[2] = 8'hFF;
        exp_out[0] = 3'd0; exp_out[1] = 3'd5; exp_out[2] = 3'd7;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            valid = 1; in = words[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out !== exp_out[i] || err !== 1'b1 || err_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL bad_%h: ov=%b out=%0d err=%b cnt=%0d want 1 %0d 1 %0d",
                         words[i], out_valid, out, err, err_cnt, exp_out[i], i + 1);
            end
            $display("bad: in=%h out=%0d err=%b cnt=%0d", in, out, err, err_cnt);
        end
        valid = 0; in = 0;
        tick();
        checks++;
        if (err_cnt !== 8'd3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_total: cnt=%0d ov=%b want 3 0", err_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        valid = 1; in = 8'h01;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 3'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: ov=%b out=%0d rdy=%b want 1 0 1", out_valid, out, ready);
        end
        in = 8'h02;
        tick();
        checks++;
        if (ready !== 1'b0 || out !== 3'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: rdy=%b out=%0d ov=%b want 0 0 1", ready, out, out_valid);
        end
        in = 8'h04;
        tick();
        checks++;
        if (ready !== 1'b0 || out !== 3'd0 || out_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b out=%0d ov=%b err=%b want 0 0 1 0", ready, out, out_valid, err);
        end
        out_ready = 1;
        tick();
        checks++;
        if (out !== 3'd1 || out_valid !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1: out=%0d ov=%b rdy=%b want 1 1 1", out, out_valid, ready);
        end
        $display("backpressure: head=%0d", out);
        tick();
        checks++;
        if (out !== 3'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop2: out=%0d ov=%b want 2 1", out, out_valid);
        end
        $display("backpressure: head=%0d", out);
        valid = 0; in = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL bp_drain: ov=%b cnt=%0d want 0 3", out_valid, err_cnt);
        end
    endtask

    task automatic test_saturation();
        out_ready2 = 1; valid2 = 1; in2 = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (err_cnt2 !== 2'((k > 3) ? 3 : k)) begin
                errors++;
                $display("FAIL sat_%0d: cnt=%0d want %0d", k, err_cnt2, (k > 3) ? 3 : k);
            end
            $display("saturation: accept %0d cnt=%0d", k, err_cnt2);
        end
        clr_cnt2 = 1;
        tick();
        checks++;
        if (err_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL sat_clear: cnt=%0d want 0", err_cnt2);
        end
        clr_cnt2 = 0; valid2 = 0;
        tick();
        checks++;
        if (err_cnt2 !== 2'd0 || out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_after_clear: cnt=%0d ov=%b want 0 0", err_cnt2, out_valid2);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; valid = 1; in = 8'h01;
        tick();
        in = 8'h80;
        tick();
        valid = 0; in = 0;
        checks++;
        if (out_valid !== 1'b1 || ready !== 1'b0 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL mid_prefill: ov=%b rdy=%b cnt=%0d want 1 0 3", out_valid, ready, err_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || ready !== 1'b0 || out !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: ov=%b cnt=%0d rdy=%b out=%0d want 0 0 0 0",
                     out_valid, err_cnt, ready, out);
        end
        tick();
        #2 rst = 1'b1;
        out_ready = 1;
        tick();
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: rdy=%b ov=%b want 1 0", ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: ov=%b out=%0d err=%b want 0 0 0", out_valid, out, err);
        end
        $display("reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_bad_words();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder8_3.md
ENCODER8_3 -- requirements
Module: encoder8_3

Interface
REQ-001 Parameter: CNT_W, 8, width of error counter err_cnt.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 Port: valid  input  1  input word present on in.
REQ-005 Port: in  input  8  one-hot word to encode.
REQ-006 Port: ready  output  1  block can accept a word this cycle.
REQ-007 Port: out_valid  output  1  out/err hold a result.
REQ-008 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-009 Port: out  output  3  encoded index of the head result.
REQ-010 Port: err  output  1  head result came from a word that was not exactly one-hot.
REQ-011 Port: clr_cnt  input  1  synchronous clear of err_cnt.
REQ-012 Port: err_cnt  output  CNT_W  saturating count of accepted non-one-hot words.

Function
REQ-013 Input accepted when valid=1 and ready=1 on a rising edge; otherwise in is ignored.
REQ-014 Encoding: out = index of highest set bit of in (in[7] -> 7, ..., in[0] -> 0).
REQ-015 err = 1 when popcount(in) != 1; in = 8'h00 -> out = 0, err = 1.
REQ-016 Multiple set bits: highest bit wins, err = 1 (e.g. 8'h24 -> out = 5, err = 1).
REQ-017 Each accepted result {out, err} pushed into a 2-entry FIFO in the accepting cycle.
REQ-018 Latency: into an empty FIFO, out_valid = 1 and result visible the cycle after acceptance.
REQ-019 out_valid = FIFO not empty; out/err = FIFO head; out = 0, err = 0 when empty.
REQ-020 Pop when out_valid=1 and out_ready=1; next entry (if any) appears the following cycle.
REQ-021 ready = 1 iff FIFO holds fewer than 2 entries and rst = 1; depends only on stored state, not on out_ready.
REQ-022 Simultaneous push and pop with 1 entry: occupancy stays 1, new result at head next cycle.
REQ-023 Full (2 entries): ready = 0; valid held by source; no data lost or duplicated.
REQ-024 Results leave in acceptance order; no reordering.
REQ-025 out/err/out_valid stable while out_valid=1 and out_ready=0.
REQ-026 err_cnt increments by 1 per accepted word with err=1, saturating at 2^CNT_W-1 (no wrap).
REQ-027 clr_cnt=1 sets err_cnt to 0 next cycle; clear wins over a simultaneous increment.
REQ-028 err_cnt counts at acceptance, not at pop.

Reset
REQ-029 rst=0 asynchronously empties FIFO: out_valid = 0, out = 0, err = 0, err_cnt = 0, ready = 0.
REQ-030 First rising edge after rst returns to 1: ready = 1, no word accepted on the release edge unless valid=1 and ready already 1.
REQ-031 Reset mid-operation discards all buffered results; none emitted after release.

Verification
REQ-032 Sweep: in = 8'h01, 02, ... 80 with out_ready=1 -> out = 0..7 in order, err = 0, 1-cycle latency, err_cnt = 0.
REQ-033 Bad words: in = 8'h00, 8'h24, 8'hFF -> (out, err) = (0,1), (5,1), (7,1); err_cnt = 3.
REQ-034 Backpressure: out_ready=0, valid=1 with 8'h01, 8'h02, 8'h04 -> ready low after 2 accepts; release out_ready -> outputs 0, 1, then 2 accepted, order kept.
REQ-035 Saturation: CNT_W=2, 5 accepted 8'h00 words -> err_cnt = 3, no wrap; clr_cnt pulse with a bad word same cycle -> err_cnt = 0.
REQ-036 Reset with 2 entries buffered, asserted between edges -> out_valid = 0 and err_cnt = 0 immediately; after release, no stale output, ready = 1.
